// File: rtl/cvm300_pkg.sv
// Shared definitions for the CVM300 readout emulator.
//   - pattern code values driven on pattern_sel
//   - FSM state encoding (also exported on the debug state port)
//   - default frame geometry and timing
//   - counter width helper
package cvm300_pkg;

    localparam int DEF_ROWS       = 488;
    localparam int DEF_COLS       = 648;
    localparam int DEF_DATA_W     = 10;
    localparam int DEF_FOT_CYCLES = 16;
    localparam int DEF_LINE_GAP   = 8;

    localparam logic [1:0] PAT_COL   = 2'd0;  // D = col
    localparam logic [1:0] PAT_ROW   = 2'd1;  // D = row
    localparam logic [1:0] PAT_INDEX = 2'd2;  // D = row*COLS + col
    localparam logic [1:0] PAT_CHECK = 2'd3;  // D = all-ones when (row^col) is odd

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FOT  = 2'd1,
        ST_LINE = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    // Bits needed to hold 0..n-1, never less than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cvm300_pixel_source_if.sv
// Sensor-side pixel bus of the CVM300 emulator.
//   Line_valid : high for the COLS cycles of each line
//   Data_valid : copy of Line_valid
//   D          : pixel value, 0 whenever Line_valid is low
// Handshake: valid-only, no ready. A pixel is transferred on every cycle in
// which Data_valid is high; the receiver cannot stall the source, so it
// must accept one pixel per clock for the whole line.
interface cvm300_pixel_source_if #(
    parameter int DATA_W = 10
);
    logic              Line_valid;
    logic              Data_valid;
    logic [DATA_W-1:0] D;

    modport master (output Line_valid, output Data_valid, output D);
    modport slave  (input  Line_valid, input  Data_valid, input  D);
endinterface

// File: rtl/cvm300_pattern_gen.sv
// Test pattern generator with registered output.
//   Clk, Reset : clock, synchronous active-high reset
//   pat_i      : latched pattern code
//   row_i      : row of the pixel to present after the next edge
//   col_i      : column of the pixel to present after the next edge
//   idx_i      : running linear pixel index (already modulo 2^DATA_W)
//   valid_i    : pixel is inside a line; otherwise D is forced to 0
//   d_o        : registered pixel value
module cvm300_pattern_gen
    import cvm300_pkg::*;
#(
    parameter int DATA_W = 10,
    parameter int ROW_W  = 9,
    parameter int COL_W  = 10
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [1:0]        pat_i,
    input  logic [ROW_W-1:0]  row_i,
    input  logic [COL_W-1:0]  col_i,
    input  logic [DATA_W-1:0] idx_i,
    input  logic              valid_i,
    output logic [DATA_W-1:0] d_o
);
    logic [DATA_W-1:0] pix_d;
    logic [DATA_W-1:0] d_q;

    always_comb begin
        pix_d = '0;
        if (valid_i) begin
            case (pat_i)
                PAT_COL:   pix_d = DATA_W'(col_i);
                PAT_ROW:   pix_d = DATA_W'(row_i);
                PAT_INDEX: pix_d = idx_i;
                default:   pix_d = {DATA_W{row_i[0] ^ col_i[0]}};
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) d_q <= '0;
        else       d_q <= pix_d;
    end

    assign d_o = d_q;
endmodule

// File: rtl/cvm300_pixel_source.sv
// CVM300 readout emulator: on a rising edge of FRAME_REQ it plays one frame
// of a deterministic test pattern on the sensor-side pixel bus.
//   Clk, Reset   : clock, synchronous active-high reset
//   FRAME_REQ    : level input, a 0->1 transition while idle starts a frame
//   pattern_sel  : pattern code, latched when the frame is accepted
//   pix          : pixel bus (Line_valid, Data_valid, D), master side
//   frame_busy   : high from accept until the last pixel has been driven
//   frame_count  : completed frames, wraps at 16 bits
//   dbg_state_o  : current FSM state
module cvm300_pixel_source
    import cvm300_pkg::*;
#(
    parameter int ROWS       = DEF_ROWS,
    parameter int COLS       = DEF_COLS,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FOT_CYCLES = DEF_FOT_CYCLES,
    parameter int LINE_GAP   = DEF_LINE_GAP
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          FRAME_REQ,
    input  logic [1:0]                    pattern_sel,
    cvm300_pixel_source_if.master         pix,
    output logic                          frame_busy,
    output logic [15:0]                   frame_count,
    output state_t                        dbg_state_o
);
    localparam int ROW_W = cnt_w(ROWS);
    localparam int COL_W = cnt_w(COLS);
    localparam int TMR_W = cnt_w(((FOT_CYCLES > LINE_GAP) ? FOT_CYCLES : LINE_GAP) + 1);

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [TMR_W-1:0] FOT_LAST = TMR_W'(FOT_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_LAST = TMR_W'(LINE_GAP - 1);

    state_t             state_q, state_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [DATA_W-1:0]  idx_q, idx_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [1:0]         pat_q, pat_d;
    logic [15:0]        count_q, count_d;
    logic               req_prev_q;
    logic               busy_q;
    logic               lv_q;
    logic               req_rise;
    logic [DATA_W-1:0]  d_w;

    assign req_rise = FRAME_REQ & ~req_prev_q;

    // Counters describe the pixel that will be on the bus after the edge,
    // so the registered outputs are computed from the next-state values.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        idx_d   = idx_q;
        tmr_d   = tmr_q;
        pat_d   = pat_q;
        count_d = count_q;
        case (state_q)
            ST_IDLE: begin
                if (req_rise) begin
                    state_d = ST_FOT;
                    pat_d   = pattern_sel;
                    row_d   = '0;
                    col_d   = '0;
                    idx_d   = '0;
                    tmr_d   = '0;
                end
            end
            ST_FOT: begin
                if (tmr_q == FOT_LAST) state_d = ST_LINE;
                else                   tmr_d   = tmr_q + 1'b1;
            end
            ST_LINE: begin
                if (col_q == COL_LAST) begin
                    if (row_q < ROW_LAST) begin
                        state_d = ST_GAP;
                        row_d   = row_q + 1'b1;
                        col_d   = '0;
                        tmr_d   = '0;
                        // Index continues across lines: next line starts at row*COLS.
                        idx_d   = idx_q + 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        count_d = count_q + 16'd1;
                    end
                end else begin
                    col_d = col_q + 1'b1;
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (tmr_q == GAP_LAST) state_d = ST_LINE;
                else                   tmr_d   = tmr_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            row_q      <= '0;
            col_q      <= '0;
            idx_q      <= '0;
            tmr_q      <= '0;
            pat_q      <= PAT_COL;
            count_q    <= '0;
            req_prev_q <= 1'b0;
            busy_q     <= 1'b0;
            lv_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            idx_q      <= idx_d;
            tmr_q      <= tmr_d;
            pat_q      <= pat_d;
            count_q    <= count_d;
            req_prev_q <= FRAME_REQ;
            busy_q     <= (state_d != ST_IDLE);
            lv_q       <= (state_d == ST_LINE);
        end
    end

    // pat_q is always settled before the first pixel since FOT_CYCLES >= 1.
    cvm300_pattern_gen #(
        .DATA_W (DATA_W),
        .ROW_W  (ROW_W),
        .COL_W  (COL_W)
    ) u_pattern_gen (
        .Clk     (Clk),
        .Reset   (Reset),
        .pat_i   (pat_q),
        .row_i   (row_d),
        .col_i   (col_d),
        .idx_i   (idx_d),
        .valid_i (state_d == ST_LINE),
        .d_o     (d_w)
    );

    assign pix.Line_valid = lv_q;
    assign pix.Data_valid = lv_q;
    assign pix.D          = d_w;
    assign frame_busy     = busy_q;
    assign frame_count    = count_q;
    assign dbg_state_o    = state_q;
endmodule

// File: tb/tb_cvm300_pixel_source.sv
// Bench for cvm300_pixel_source: a small-geometry instance checked cycle by
// cycle against an arithmetic frame timeline, and a medium-geometry instance
// checked with an expected-pixel queue and frame statistics.
module tb_cvm300_pixel_source;
    import cvm300_pkg::*;

    localparam int DW     = 10;
    localparam int S_ROWS = 3;
    localparam int S_COLS = 4;
    localparam int S_FOT  = 2;
    localparam int S_GAP  = 2;
    localparam int S_FLEN = S_FOT + S_ROWS * S_COLS + (S_ROWS - 1) * S_GAP;
    localparam int L_ROWS = 24;
    localparam int L_COLS = 100;
    localparam int L_FOT  = 16;
    localparam int L_GAP  = 8;
    localparam int L_PIX  = L_ROWS * L_COLS;
    localparam int L_FLEN = L_FOT + L_PIX + (L_ROWS - 1) * L_GAP;

    // ---------------- clock / reset ----------------
    logic Clk = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    logic        req_s = 1'b0;
    logic [1:0]  pattern_sel_s = 2'd0;
    logic        busy_s;
    logic [15:0] frame_count_s;
    state_t      state_s;
    logic        req_l = 1'b0;
    logic [1:0]  pattern_sel_l = 2'd0;
    logic        busy_l;
    logic [15:0] frame_count_l;
    state_t      state_l;

    cvm300_pixel_source_if #(.DATA_W(DW)) pix_s ();
    cvm300_pixel_source_if #(.DATA_W(DW)) pix_l ();

    cvm300_pixel_source #(
        .ROWS(S_ROWS), .COLS(S_COLS), .DATA_W(DW), .FOT_CYCLES(S_FOT), .LINE_GAP(S_GAP)
    ) dut_s (
        .Clk(Clk), .Reset(Reset), .FRAME_REQ(req_s), .pattern_sel(pattern_sel_s),
        .pix(pix_s), .frame_busy(busy_s), .frame_count(frame_count_s), .dbg_state_o(state_s)
    );

    cvm300_pixel_source #(
        .ROWS(L_ROWS), .COLS(L_COLS), .DATA_W(DW), .FOT_CYCLES(L_FOT), .LINE_GAP(L_GAP)
    ) dut_l (
        .Clk(Clk), .Reset(Reset), .FRAME_REQ(req_l), .pattern_sel(pattern_sel_l),
        .pix(pix_l), .frame_busy(busy_l), .frame_count(frame_count_l), .dbg_state_o(state_l)
    );

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_bad = 0;
    int exp_count_s = 0;
    logic [DW-1:0] exp_q[$];

    // Pixel value from the pattern definitions, plain arithmetic.
    function automatic logic [DW-1:0] pix_model(input int pat, input int r, input int c, input int cols);
        int v;
        case (pat)
            0:       v = c;
            1:       v = r;
            2:       v = r * cols + c;
            default: v = ((r ^ c) & 1) ? (1 << DW) - 1 : 0;
        endcase
        return DW'(v % (1 << DW));
    endfunction

    // Accept edge is the next posedge. Samples at each negedge after edge k+n.
    task automatic observe_small_frame(input int pat, input bit poke);
        for (int n = 0; n <= S_FLEN + 1; n++) begin
            int t, off, row;
            logic e_lv, e_busy;
            logic [DW-1:0] e_d;
            logic [15:0] e_cnt;
            @(negedge Clk);
            t      = n - S_FOT;
            off    = (t >= 0) ? t % (S_COLS + S_GAP) : 0;
            row    = (t >= 0) ? t / (S_COLS + S_GAP) : 0;
            e_busy = (n < S_FLEN);
            e_lv   = (t >= 0) && (n < S_FLEN) && (off < S_COLS);
            e_d    = e_lv ? pix_model(pat, row, off, S_COLS) : '0;
            e_cnt  = 16'(exp_count_s + ((n >= S_FLEN) ? 1 : 0));
            n_cmp += 5;
            if (pix_s.Line_valid !== e_lv) begin
                n_bad++; $display("FAIL line_valid n=%0d got %b want %b", n, pix_s.Line_valid, e_lv);
            end
            if (pix_s.Data_valid !== e_lv) begin
                n_bad++; $display("FAIL data_valid n=%0d got %b want %b", n, pix_s.Data_valid, e_lv);
            end
            if (pix_s.D !== e_d) begin
                n_bad++; $display("FAIL pixel pat=%0d n=%0d got %h want %h", pat, n, pix_s.D, e_d);
            end
            if (busy_s !== e_busy) begin
                n_bad++; $display("FAIL frame_busy n=%0d got %b want %b", n, busy_s, e_busy);
            end
            if (frame_count_s !== e_cnt) begin
                n_bad++; $display("FAIL frame_count n=%0d got %0d want %0d", n, frame_count_s, e_cnt);
            end
            // Mid-frame pattern changes must not affect this frame.
            pattern_sel_s = 2'($urandom_range(0, 3));
            if (poke && n == 4) req_s = 1'b0;
            if (poke && n == 5) req_s = 1'b1;
        end
        exp_count_s++;
    endtask

    task automatic run_small_frame(input int pat, input bit poke);
        @(negedge Clk);
        req_s = 1'b0;
        @(negedge Clk);
        pattern_sel_s = 2'(pat);
        req_s = 1'b1;
        observe_small_frame(pat, poke);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        n_cmp += 8;
        if (pix_s.Line_valid !== 1'b0) begin n_bad++; $display("FAIL reset_lv_s got %b want 0", pix_s.Line_valid); end
        if (pix_s.Data_valid !== 1'b0) begin n_bad++; $display("FAIL reset_dv_s got %b want 0", pix_s.Data_valid); end
        if (pix_s.D !== '0)            begin n_bad++; $display("FAIL reset_d_s got %h want 0", pix_s.D); end
        if (busy_s !== 1'b0)           begin n_bad++; $display("FAIL reset_busy_s got %b want 0", busy_s); end
        if (frame_count_s !== 16'd0)   begin n_bad++; $display("FAIL reset_count_s got %0d want 0", frame_count_s); end
        if (pix_l.Line_valid !== 1'b0) begin n_bad++; $display("FAIL reset_lv_l got %b want 0", pix_l.Line_valid); end
        if (busy_l !== 1'b0)           begin n_bad++; $display("FAIL reset_busy_l got %b want 0", busy_l); end
        if (frame_count_l !== 16'd0)   begin n_bad++; $display("FAIL reset_count_l got %0d want 0", frame_count_l); end
        Reset = 1'b0;
        exp_count_s = 0;
    endtask

    task automatic test_patterns();
        for (int p = 0; p < 4; p++) run_small_frame(p, 1'b0);
    endtask

    task automatic test_random_frames();
        repeat (4) begin
            @(negedge Clk);
            req_s = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge Clk);
            run_small_frame(int'($urandom_range(0, 3)), 1'b0);
        end
    endtask

    task automatic test_req_ignored();
        run_small_frame(int'($urandom_range(0, 3)), 1'b1);
        // FRAME_REQ still high: no new frame may start.
        repeat (8) begin
            @(negedge Clk);
            n_cmp += 2;
            if (busy_s !== 1'b0) begin n_bad++; $display("FAIL held_req_busy got %b want 0", busy_s); end
            if (frame_count_s !== 16'(exp_count_s)) begin
                n_bad++; $display("FAIL held_req_count got %0d want %0d", frame_count_s, exp_count_s);
            end
        end
        run_small_frame(int'($urandom_range(0, 3)), 1'b0);
    endtask

    task automatic test_reset_mid_frame();
        @(negedge Clk);
        req_s = 1'b0;
        @(negedge Clk);
        pattern_sel_s = 2'd2;
        req_s = 1'b1;
        // Ten negedges after accept: row 1, column 1.
        repeat (S_FOT + S_COLS + S_GAP + 2) @(negedge Clk);
        n_cmp += 2;
        if (pix_s.Line_valid !== 1'b1) begin n_bad++; $display("FAIL mid_row1_lv got %b want 1", pix_s.Line_valid); end
        if (pix_s.D !== pix_model(2, 1, 1, S_COLS)) begin
            n_bad++; $display("FAIL mid_row1_d got %h want %h", pix_s.D, pix_model(2, 1, 1, S_COLS));
        end
        Reset = 1'b1;
        req_s = 1'b0;
        @(negedge Clk);
        n_cmp += 5;
        if (pix_s.Line_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_lv got %b want 0", pix_s.Line_valid); end
        if (pix_s.Data_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_dv got %b want 0", pix_s.Data_valid); end
        if (pix_s.D !== '0)            begin n_bad++; $display("FAIL rst_mid_d got %h want 0", pix_s.D); end
        if (busy_s !== 1'b0)           begin n_bad++; $display("FAIL rst_mid_busy got %b want 0", busy_s); end
        if (frame_count_s !== 16'd0)   begin n_bad++; $display("FAIL rst_mid_count got %0d want 0", frame_count_s); end
        Reset = 1'b0;
        exp_count_s = 0;
        run_small_frame(int'($urandom_range(0, 3)), 1'b0);
    endtask

    task automatic test_req_at_reset_release();
        int p;
        p = int'($urandom_range(0, 3));
        @(negedge Clk);
        Reset = 1'b1;
        req_s = 1'b1;
        pattern_sel_s = 2'(p);
        @(negedge Clk);
        Reset = 1'b0;
        exp_count_s = 0;
        observe_small_frame(p, 1'b0);
        req_s = 1'b0;
    endtask

    task automatic test_large_frame();
        int busy_cyc, dv_cnt, rises, cyc;
        bit seen_busy, done, prev_lv;
        logic [DW-1:0] last_d, e_d;
        busy_cyc = 0; dv_cnt = 0; rises = 0; cyc = 0;
        seen_busy = 0; done = 0; prev_lv = 0; last_d = '0;
        exp_q.delete();
        for (int p = 0; p < L_PIX; p++) exp_q.push_back(DW'(p % (1 << DW)));
        @(negedge Clk);
        req_l = 1'b0;
        @(negedge Clk);
        pattern_sel_l = 2'd2;
        req_l = 1'b1;
        while (!done && cyc < L_FLEN + 200) begin
            @(negedge Clk);
            cyc++;
            pattern_sel_l = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) req_l = ~req_l;
            if (busy_l) begin busy_cyc++; seen_busy = 1; end
            else if (seen_busy) done = 1;
            if (pix_l.Line_valid && !prev_lv) rises++;
            prev_lv = pix_l.Line_valid;
            n_cmp++;
            if (pix_l.Data_valid !== pix_l.Line_valid) begin
                n_bad++; $display("FAIL large_dv_eq_lv cyc=%0d got %b want %b", cyc, pix_l.Data_valid, pix_l.Line_valid);
            end
            if (pix_l.Data_valid === 1'b1) begin
                dv_cnt++;
                last_d = pix_l.D;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++; $display("FAIL large_extra_pixel cyc=%0d got %h want none", cyc, pix_l.D);
                end else begin
                    e_d = exp_q.pop_front();
                    if (pix_l.D !== e_d) begin
                        n_bad++; $display("FAIL large_pixel cyc=%0d got %h want %h", cyc, pix_l.D, e_d);
                    end
                end
            end
        end
        req_l = 1'b0;
        n_cmp += 7;
        if (!done) begin n_bad++; $display("FAIL large_timeout got busy=%b after %0d cycles want frame end", busy_l, cyc); end
        if (dv_cnt != L_PIX) begin n_bad++; $display("FAIL large_dv_count got %0d want %0d", dv_cnt, L_PIX); end
        if (rises != L_ROWS) begin n_bad++; $display("FAIL large_lines got %0d want %0d", rises, L_ROWS); end
        if (last_d !== DW'((L_PIX - 1) % (1 << DW))) begin
            n_bad++; $display("FAIL large_last_d got %h want %h", last_d, DW'((L_PIX - 1) % (1 << DW)));
        end
        if (busy_cyc != L_FLEN) begin n_bad++; $display("FAIL large_frame_len got %0d want %0d", busy_cyc, L_FLEN); end
        if (frame_count_l !== 16'd1) begin n_bad++; $display("FAIL large_count got %0d want 1", frame_count_l); end
        if (exp_q.size() != 0) begin n_bad++; $display("FAIL large_missing got %0d left want 0", exp_q.size()); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_patterns();
        test_random_frames();
        test_req_ignored();
        test_reset_mid_frame();
        test_req_at_reset_release();
        test_large_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
